dec_frame_host: RTL

Host-side frame adapter for the convolutional encoder/decoder core. It accepts received code bits as a byte stream with a valid/ready handshake and assembles one 384-bit decoder data frame. It then drives the core's enable and code-rate inputs, waits for the decoder-done indication, and streams the 128 decoded bits back out as bytes. It sits between the system bus/DMA byte interface and the core's parallel frame ports, one frame in flight at a time.

---
 rtl/dec_frame_host.sv | 90 +++++++++
 1 files changed

// File: rtl/dec_frame_host.sv
// dec_frame_host: byte-stream adapter that loads a decoder frame, runs the core, and unloads decoded bytes.
module dec_frame_host #(
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic         sys_clk,
    input  logic         rst,
    input  logic         i_code_rate,
    input  logic [7:0]   s_data,
    input  logic         s_valid,
    output logic         s_ready,
    output logic [383:0] o_decoder_data_frame,
    output logic         o_code_rate,
    output logic         o_endec_en,
    input  logic [127:0] i_decoder_data,
    input  logic         i_decoder_done,
    output logic [7:0]   m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         o_timeout,
    output logic [15:0]  o_frame_cnt
);
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {LOAD, RUN, UNLOAD} state_t;

    state_t         state, state_nxt;
    logic [5:0]     cnt;
    logic [WDW-1:0] wd;
    logic [127:0]   shreg;
    logic [383:0]   frame_nxt;
    logic           s_fire, m_fire, last_in, last_out, rate_now, timeout_hit;

    assign s_ready     = state == LOAD;
    assign o_endec_en  = state == RUN;
    assign m_valid     = state == UNLOAD;
    assign m_data      = shreg[7:0];
    assign s_fire      = s_ready && s_valid;
    assign m_fire      = m_valid && m_ready;
    // the rate applies from the very first byte, before it is latched
    assign rate_now    = (cnt == 6'd0) ? i_code_rate : o_code_rate;
    assign last_in     = cnt == (rate_now ? 6'd47 : 6'd31);
    assign last_out    = cnt == 6'd15;
    assign timeout_hit = wd == WDW'(TIMEOUT_CYC - 1);

    always_comb begin
        frame_nxt = ((cnt == 6'd0) ? 384'd0 : o_decoder_data_frame) & ~(384'hFF << {cnt, 3'b000});
        frame_nxt = frame_nxt | (384'(s_data) << {cnt, 3'b000});
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LOAD:    state_nxt = (s_fire && last_in) ? RUN : LOAD;
            RUN:     state_nxt = i_decoder_done ? UNLOAD : (timeout_hit ? LOAD : RUN);
            UNLOAD:  state_nxt = (m_fire && last_out) ? LOAD : UNLOAD;
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state                <= LOAD;
            cnt                  <= '0;
            wd                   <= '0;
            shreg                <= '0;
            o_decoder_data_frame <= '0;
            o_code_rate          <= 1'b0;
            o_timeout            <= 1'b0;
            o_frame_cnt          <= '0;
        end else begin
            state     <= state_nxt;
            wd        <= (state == RUN) ? wd + WDW'(1) : '0;
            o_timeout <= (state == RUN) && !i_decoder_done && timeout_hit;
            if (s_fire) begin
                o_decoder_data_frame <= frame_nxt;
                if (cnt == 6'd0)
                    o_code_rate <= i_code_rate;
                cnt <= last_in ? 6'd0 : cnt + 6'd1;
            end
            if (state == RUN && i_decoder_done)
                shreg <= i_decoder_data;
            if (m_fire) begin
                shreg <= shreg >> 8;
                cnt   <= last_out ? 6'd0 : cnt + 6'd1;
                if (last_out)
                    o_frame_cnt <= o_frame_cnt + 16'd1;
            end
        end
    end
endmodule
